// File: rtl/vga_video_core_if.sv
// Pixel-source request bus between the VGA core and a pixel source
// (framebuffer, glyph renderer).
//   req_x, req_y : current raster position requested by the core
//   req_valid    : the requested position lies in the visible area
//   src_pixel    : source data, returned a fixed number of pix_ce ticks after the request
// master = video core side, slave = pixel source side.
interface vga_video_core_if #(
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 10,
    parameter int unsigned PIXEL_BITS = 3
);
    logic [XW-1:0]         req_x;
    logic [YW-1:0]         req_y;
    logic                  req_valid;
    logic [PIXEL_BITS-1:0] src_pixel;

    modport master (
        output req_x,
        output req_y,
        output req_valid,
        input  src_pixel
    );

    modport slave (
        input  req_x,
        input  req_y,
        input  req_valid,
        output src_pixel
    );
endinterface

// File: rtl/vga_video_core.sv
// Parametrised VGA video core: raster timing generator, pixel-source request port,
// built-in test patterns (colour bars, grid, solid) and a delay pipeline that keeps
// pattern, blanking, syncs and start flags aligned with the source read latency.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pix_ce            : pixel clock enable; all state advances only when high
//   mode              : 0 source, 1 colour bars, 2 grid, 3 solid (latched per frame)
//   solid_color       : colour for solid mode
//   src               : request bus (req_x/req_y/req_valid out, src_pixel in)
//   pixel             : registered pixel to the DAC
//   hsync_out/vsync_out : syncs aligned with pixel
//   frame_start/line_start : one-clk pulses with pixel (0,0) / pixel (0,y)
module vga_video_core #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        HSYNC_POL   = 1'b0,
    parameter logic        VSYNC_POL   = 1'b0,
    parameter int unsigned PIXEL_BITS  = 3,
    parameter int unsigned SRC_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_ce,
    input  logic [1:0]            mode,
    input  logic [PIXEL_BITS-1:0] solid_color,
    vga_video_core_if.master      src,
    output logic [PIXEL_BITS-1:0] pixel,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  frame_start,
    output logic                  line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);
    localparam int unsigned CW      = PIXEL_BITS / 3;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] XLast      = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] XActive    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] XActLast   = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] XSyncFirst = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] XSyncLast  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] YLast      = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] YActive    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] YActLast   = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] YSyncFirst = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] YSyncLast  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [BW-1:0] BarSubLast = BW'(BAR_W - 1);

    typedef enum logic [1:0] {
        ModeSrc   = 2'd0,
        ModeBars  = 2'd1,
        ModeGrid  = 2'd2,
        ModeSolid = 2'd3
    } mode_t;

    // One pipeline slot: everything about a raster position except the source pixel.
    typedef struct packed {
        logic                  vld;
        logic                  act;
        logic                  hs;
        logic                  vs;
        logic                  fs;
        logic                  ls;
        logic                  use_src;
        logic [PIXEL_BITS-1:0] pat;
    } stage_t;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] bar_sub_q, bar_sub_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    mode_t         mode_q, mode_d;

    logic x_act, y_act, x_grid, y_grid;
    stage_t s0, last;
    stage_t pipe_q [SRC_LATENCY];

    logic [PIXEL_BITS-1:0] pixel_q, pixel_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d;
    logic frame_start_q, frame_start_d, line_start_q, line_start_d;

    assign x_act = (x_q < XActive);
    assign y_act = (y_q < YActive);

    // Grid lines every 16 pixels; with a counter narrower than 4 bits only 0 qualifies.
    if (XW >= 4) begin : g_xgrid_wide
        assign x_grid = (x_q[3:0] == 4'd0);
    end else begin : g_xgrid_narrow
        assign x_grid = (x_q == '0);
    end
    if (YW >= 4) begin : g_ygrid_wide
        assign y_grid = (y_q[3:0] == 4'd0);
    end else begin : g_ygrid_narrow
        assign y_grid = (y_q == '0);
    end

    assign src.req_x     = x_q;
    assign src.req_y     = y_q;
    assign src.req_valid = x_act && y_act;

    // Raster counters; the bar sub-counter tracks x/BAR_W without a divider.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        bar_sub_d = bar_sub_q;
        bar_idx_d = bar_idx_q;
        mode_d    = mode_q;
        if (x_q == XLast) begin
            x_d       = '0;
            bar_sub_d = '0;
            bar_idx_d = '0;
            if (y_q == YLast) begin
                y_d    = '0;
                mode_d = mode_t'(mode);
            end else begin
                y_d = y_q + YW'(1);
            end
        end else begin
            x_d = x_q + XW'(1);
            if (bar_sub_q == BarSubLast) begin
                bar_sub_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_sub_d = bar_sub_q + BW'(1);
            end
        end
    end

    // Stage 0: pattern and flags for the current counter position.
    always_comb begin
        s0         = '0;
        s0.vld     = 1'b1;
        s0.act     = x_act && y_act;
        s0.hs      = (x_q >= XSyncFirst) && (x_q <= XSyncLast);
        s0.vs      = (y_q >= YSyncFirst) && (y_q <= YSyncLast);
        s0.fs      = (x_q == '0) && (y_q == '0);
        s0.ls      = (x_q == '0) && y_act;
        s0.use_src = (mode_q == ModeSrc);
        unique case (mode_q)
            ModeBars: begin
                // Channel c (0 = B, 2 = R) is lit by bar index bit c.
                for (int c = 0; c < 3; c++) begin
                    s0.pat[c*CW +: CW] = {CW{bar_idx_q[c]}};
                end
            end
            ModeGrid: begin
                if (x_grid || y_grid || (x_q == XActLast) || (y_q == YActLast)) begin
                    s0.pat = '1;
                end
            end
            ModeSolid: s0.pat = solid_color;
            default:   s0.pat = '0;
        endcase
    end

    assign last = pipe_q[SRC_LATENCY-1];

    always_comb begin
        pixel_d       = '0;
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        if (last.vld) begin
            if (last.act) begin
                pixel_d = last.use_src ? src.src_pixel : last.pat;
            end
            hsync_d       = last.hs ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = last.vs ? VSYNC_POL : ~VSYNC_POL;
            frame_start_d = last.fs;
            line_start_d  = last.ls;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            bar_sub_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= ModeSrc;
            for (int i = 0; i < SRC_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (pix_ce) begin
            x_q       <= x_d;
            y_q       <= y_d;
            bar_sub_q <= bar_sub_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            for (int i = SRC_LATENCY - 1; i > 0; i--) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pipe_q[0] <= s0;
        end
    end

    // Output stage; start pulses drop on the first non-ce edge so they stay one clk wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q       <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else if (pix_ce) begin
            pixel_q       <= pixel_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end else begin
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end
    end

    assign pixel       = pixel_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_video_core.sv
// Self-checking bench for vga_video_core on a 16x8 raster. A behavioural model tracks
// the raster position as a linear index, queues one descriptor per consumed position and
// predicts outputs from the timing rules; the pixel source is emulated by echoing a hash
// of each request back SRC_LATENCY ce-ticks later.
module tb_vga_video_core;

    localparam int unsigned H_ACTIVE = 8;
    localparam int unsigned H_FP     = 2;
    localparam int unsigned H_SYNC   = 3;
    localparam int unsigned H_BP     = 3;
    localparam int unsigned V_ACTIVE = 4;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 1;
    localparam int unsigned PB       = 3;
    localparam int unsigned LAT      = 2;
    localparam logic        HP       = 1'b0;
    localparam logic        VP       = 1'b0;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int CW      = PB / 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_ce;
    logic [1:0]    mode;
    logic [PB-1:0] solid_color;
    logic [PB-1:0] pixel;
    logic          hsync_out, vsync_out, frame_start, line_start;

    vga_video_core_if #(.XW(XW), .YW(YW), .PIXEL_BITS(PB)) src_if ();

    vga_video_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .PIXEL_BITS(PB), .SRC_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_ce(pix_ce),
        .mode(mode),
        .solid_color(solid_color),
        .src(src_if),
        .pixel(pixel),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .frame_start(frame_start),
        .line_start(line_start)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int            x;
        int            y;
        int            md;
        logic [PB-1:0] sc;
    } desc_t;

    desc_t         q[$];
    int            pos;
    int            cur_mode;
    logic [PB-1:0] e_pix;
    logic          e_hs, e_vs, e_fs, e_ls;
    int            hist_x[LAT];
    int            hist_y[LAT];
    bit            hist_v[LAT];

    function automatic logic [PB-1:0] src_val(input int x, input int y);
        return PB'(x + 3 * y);
    endfunction

    function automatic logic [PB-1:0] exp_pixel(input desc_t d);
        int b;
        int v;
        if (!(d.x < H_ACTIVE && d.y < V_ACTIVE)) return '0;
        case (d.md)
            0: return src_val(d.x, d.y);
            1: begin
                b = d.x / (H_ACTIVE / 8);
                v = 0;
                for (int ch = 0; ch < 3; ch++)
                    if (((b >> ch) & 1) == 1) v = v | (((1 << CW) - 1) << (ch * CW));
                return PB'(v);
            end
            2: begin
                if (d.x % 16 == 0 || d.y % 16 == 0 || d.x == H_ACTIVE - 1 ||
                    d.y == V_ACTIVE - 1) return '1;
                return '0;
            end
            default: return d.sc;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic ce, input logic [1:0] m,
                         input logic [PB-1:0] sc);
        desc_t d;
        desc_t o;
        int    rx, ry;
        bit    rv;
        rst         = r;
        pix_ce      = ce;
        mode        = m;
        solid_color = sc;
        if (hist_v[LAT-1]) src_if.src_pixel = src_val(hist_x[LAT-1], hist_y[LAT-1]);
        else src_if.src_pixel = PB'($urandom);
        rx = int'(src_if.req_x);
        ry = int'(src_if.req_y);
        rv = src_if.req_valid;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            pos      = 0;
            cur_mode = 0;
            e_pix    = '0;
            e_hs     = ~HP;
            e_vs     = ~VP;
            e_fs     = 1'b0;
            e_ls     = 1'b0;
        end else if (ce) begin
            e_fs = 1'b0;
            e_ls = 1'b0;
            if (q.size() >= LAT) begin
                o     = q.pop_front();
                e_pix = exp_pixel(o);
                e_hs  = (o.x >= H_ACTIVE + H_FP && o.x < H_ACTIVE + H_FP + H_SYNC) ? HP : ~HP;
                e_vs  = (o.y >= V_ACTIVE + V_FP && o.y < V_ACTIVE + V_FP + V_SYNC) ? VP : ~VP;
                e_fs  = (o.x == 0 && o.y == 0);
                e_ls  = (o.x == 0 && o.y < V_ACTIVE);
            end else begin
                e_pix = '0;
                e_hs  = ~HP;
                e_vs  = ~VP;
            end
            d = '{x: pos % H_TOTAL, y: pos / H_TOTAL, md: cur_mode, sc: sc};
            q.push_back(d);
            pos = (pos + 1) % FRAME;
            if (pos == 0) cur_mode = int'(m);
        end else begin
            e_fs = 1'b0;
            e_ls = 1'b0;
        end
        check("pixel", 32'(pixel), 32'(e_pix));
        check("hsync", 32'(hsync_out), 32'(e_hs));
        check("vsync", 32'(vsync_out), 32'(e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("line_start", 32'(line_start), 32'(e_ls));
        check("req_x", 32'(src_if.req_x), 32'(pos % H_TOTAL));
        check("req_y", 32'(src_if.req_y), 32'(pos / H_TOTAL));
        check("req_valid", 32'(src_if.req_valid),
              32'((pos % H_TOTAL) < H_ACTIVE && (pos / H_TOTAL) < V_ACTIVE));
        if (ce) begin
            for (int i = LAT - 1; i > 0; i--) begin
                hist_x[i] = hist_x[i-1];
                hist_y[i] = hist_y[i-1];
                hist_v[i] = hist_v[i-1];
            end
            hist_x[0] = rx;
            hist_y[0] = ry;
            hist_v[0] = rv;
        end
    endtask

    initial begin
        logic [1:0] m;
        checks = 0;
        errors = 0;
        for (int i = 0; i < LAT; i++) begin
            hist_x[i] = 0;
            hist_y[i] = 0;
            hist_v[i] = 1'b0;
        end
        rst              = 1'b1;
        pix_ce           = 1'b1;
        mode             = 2'd0;
        solid_color      = '0;
        src_if.src_pixel = '0;

        repeat (3) cycle(1'b1, 1'b1, 2'd0, '0);
        // Source mode from release, two full frames.
        repeat (2 * FRAME) cycle(1'b0, 1'b1, 2'd0, PB'($urandom));
        // Colour bars requested mid-frame.
        repeat ($urandom_range(10, 100)) cycle(1'b0, 1'b1, 2'd0, PB'($urandom));
        repeat (2 * FRAME) cycle(1'b0, 1'b1, 2'd1, PB'($urandom));
        // Solid 5, then grid.
        repeat (FRAME + 20) cycle(1'b0, 1'b1, 2'd3, PB'(5));
        repeat (2 * FRAME) cycle(1'b0, 1'b1, 2'd2, PB'($urandom));
        // Half-rate pixel enable in source mode.
        for (int i = 0; i < 4 * FRAME; i++) cycle(1'b0, (i % 2) == 0, 2'd0, PB'($urandom));
        // Single-cycle reset mid-line, then recovery.
        repeat (37) cycle(1'b0, 1'b1, 2'd1, PB'($urandom));
        cycle(1'b1, 1'b1, 2'd1, PB'($urandom));
        repeat (2 * FRAME) cycle(1'b0, 1'b1, 2'd0, PB'($urandom));
        // Random soak: sparse ce, mode changes, occasional reset.
        m = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) m = 2'($urandom);
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, m, PB'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
